// File: rtl/dbus_ram.sv
// Word-addressed 64-bit RAM behind a data-bus slave port, with a fixed WAIT latency,
// read-before-write byte-strobed commits and a backdoor word-write port.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

// state | meaning
// IDLE  | ready; addr_ok follows valid
// WAIT  | counting down LATENCY cycles
// RESP  | data_ok for one cycle; write commits on exit
module dbus_ram
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  input  logic        bd_we,
  input  logic [63:0] bd_addr,
  input  logic [63:0] bd_wdata,
  output logic        err,
  output logic [31:0] served
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [63:0]    rdata;
  logic [AW-1:0]  idx_q;
  logic           in_q;
  logic [7:0]     strobe_q;
  logic [63:0]    wdata_q;
  logic [63:0]    mem [MEM_WORDS];

  // Wrap-around offsets; anything above the index bits must be zero to be in range.
  logic [63:0] off, bd_off;
  logic        in_rng, bd_in_rng;
  logic        commit;
  logic        unused_bits;

  assign off       = dreq.addr - BASE_ADDR;
  assign bd_off    = bd_addr - BASE_ADDR;
  assign in_rng    = (off[63:AW+3] == '0);
  assign bd_in_rng = (bd_off[63:AW+3] == '0);
  assign commit    = (state == RESP) && in_q && !rst;
  assign unused_bits = ^{dreq.size, off[2:0], bd_off[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata    <= '0;
      served   <= '0;
      idx_q    <= '0;
      in_q     <= 1'b0;
      strobe_q <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (dreq.valid) begin
          idx_q    <= off[AW+2:3];
          in_q     <= in_rng;
          strobe_q <= dreq.strobe;
          wdata_q  <= dreq.data;
          cnt      <= 4'(LATENCY);
          state    <= WAIT;
        end
        WAIT: if (cnt == 4'd1) begin
          cnt   <= '0;
          rdata <= in_q ? mem[idx_q] : '0;
          state <= RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          served <= served + 32'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset; the front-door write follows the backdoor so its bytes win.
  always_ff @(posedge clk) begin
    if (bd_we && bd_in_rng) mem[bd_off[AW+2:3]] <= bd_wdata;
    if (commit) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = (state == IDLE) && dreq.valid && !rst;
    dresp.data_ok = (state == RESP);
    dresp.data    = rdata;
  end

  assign err = (state == RESP) && !in_q;
endmodule

// File: tb/tb_dbus_ram.sv
// Directed bench for dbus_ram: reads, strobed writes, range errors, back-to-back
// requests, mid-transaction reset and same-edge backdoor/front-door collisions.
module tb_dbus_ram;
  import dbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        bd_we;
  logic [63:0] bd_addr, bd_wdata;
  logic        err;
  logic [31:0] served;

  int checks = 0;
  int failures = 0;

  dbus_ram dut (
    .clk(clk), .rst(rst), .dreq(dreq), .dresp(dresp),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
    .err(err), .served(served)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [63:0] a, input logic [63:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Starts just after a negedge in IDLE, returns just after the negedge following RESP.
  task automatic do_req(input logic [63:0] a, input logic [7:0] strb, input logic [63:0] d,
                        output logic acc, output int lat, output logic [63:0] rd,
                        output logic err_r, output logic err_after);
    dreq.valid = 1'b1; dreq.addr = a; dreq.strobe = strb; dreq.data = d; dreq.size = 3'd3;
    #1 acc = dresp.addr_ok;
    @(negedge clk); #1;
    dreq.valid = 1'b0;
    lat = 1;
    while (!dresp.data_ok && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    rd = dresp.data;
    err_r = err;
    @(negedge clk); #1;
    err_after = err;
  endtask

  logic        acc, e1, e2;
  int          lat;
  logic [63:0] rd;
  logic [31:0] exp_served;
  int          acc_n, dk_n;
  int          acc_t [4];

  initial begin
    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    dreq = '0;
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0010;
    @(negedge clk); #1;
    check("rst_addr_ok", dresp.addr_ok, 0);
    check("rst_data_ok", dresp.data_ok, 0);
    check("rst_data", dresp.data, 0);
    check("rst_err", err, 0);
    check("rst_served", served, 0);
    dreq.valid = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    exp_served = 0;

    // backdoor then read
    bd_write(64'h8000_0010, 64'h1122334455667788);
    do_req(64'h8000_0010, 8'h00, 64'h0, acc, lat, rd, e1, e2);
    exp_served++;
    check("rd_accept", acc, 1);
    check("rd_latency", lat, 3);
    check("rd_data", rd, 64'h1122334455667788);
    check("rd_err", e1, 0);

    // strobed write returns old word, then read merged word
    do_req(64'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, acc, lat, rd, e1, e2);
    exp_served++;
    check("wr_old_data", rd, 64'h1122334455667788);
    check("wr_latency", lat, 3);
    do_req(64'h8000_0010, 8'h00, 64'h0, acc, lat, rd, e1, e2);
    exp_served++;
    check("wr_merged", rd, 64'h11223344_BBBBBBBB);

    // out-of-range below base and one past the end
    do_req(64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, acc, lat, rd, e1, e2);
    exp_served++;
    check("oor_lo_data", rd, 0);
    check("oor_lo_err", e1, 1);
    check("oor_lo_err_after", e2, 0);
    check("oor_lo_latency", lat, 3);
    do_req(64'h8000_0000 + 64'd8 * 64'd4096, 8'h00, 64'h0, acc, lat, rd, e1, e2);
    exp_served++;
    check("oor_hi_data", rd, 0);
    check("oor_hi_err", e1, 1);
    check("oor_hi_err_after", e2, 0);
    check("oor_served", served, exp_served);
    do_req(64'h8000_0010, 8'h00, 64'h0, acc, lat, rd, e1, e2);
    check("oor_mem_unchanged", rd, 64'h11223344_BBBBBBBB);
    check("oor_rd_err", e1, 0);

    // back-to-back with valid held high
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0010; dreq.strobe = 8'h00;
    acc_n = 0; dk_n = 0;
    for (int c = 0; c < 16; c++) begin
      if (acc_n == 3) dreq.valid = 1'b0;
      #1;
      if (dresp.data_ok) dk_n++;
      if (dresp.addr_ok) begin
        if (acc_n < 4) acc_t[acc_n] = c;
        acc_n++;
      end
      @(negedge clk);
    end
    #1;
    check("b2b_accepts", acc_n, 3);
    check("b2b_data_oks", dk_n, 3);
    check("b2b_gap01", acc_t[1] - acc_t[0], 4);
    check("b2b_gap12", acc_t[2] - acc_t[1], 4);
    check("b2b_served", served, 3);

    // reset during WAIT of a full write
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0010; dreq.strobe = 8'hFF;
    dreq.data = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk); #1;
    dreq.valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_served", served, 0);
    check("mid_rst_data_ok", dresp.data_ok, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    dk_n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (dresp.data_ok) dk_n++;
    end
    check("mid_rst_no_data_ok", dk_n, 0);
    check("mid_rst_served_after", served, 0);
    do_req(64'h8000_0010, 8'h00, 64'h0, acc, lat, rd, e1, e2);
    check("mid_rst_word_kept", rd, 64'h11223344_BBBBBBBB);
    check("mid_rst_next_accept", acc, 1);
    check("mid_rst_next_latency", lat, 3);
    check("mid_rst_next_served", served, 1);

    // same-edge backdoor and front-door commit to one word
    bd_write(64'h8000_0020, 64'h5555_5555_5555_5555);
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0020; dreq.strobe = 8'hF0;
    dreq.data = 64'hFFFFFFFF_00000000;
    @(negedge clk); #1;
    dreq.valid = 1'b0;
    lat = 1;
    while (!dresp.data_ok && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    check("coll_latency", lat, 3);
    bd_write(64'h8000_0020, 64'h0);
    do_req(64'h8000_0020, 8'h00, 64'h0, acc, lat, rd, e1, e2);
    check("coll_word", rd, 64'hFFFFFFFF_00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
